// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run control, halt detection and verdict latch for the RV32I core
module cpu_run_monitor #(
   parameter int XLEN           = 32,
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 32,
   parameter int LOOP_LIMIT     = 2
) (
   input  logic             clk,
   input  logic             reset,
   output logic             core_reset,
   input  logic             retire_valid,
   input  logic [XLEN-1:0]  retire_pc,
   input  logic [31:0]      retire_inst,
   input  logic [XLEN-1:0]  a0_value,
   input  logic             halt_req,
   output logic [2:0]       state,
   output logic             done,
   output logic             pass,
   output logic [XLEN-1:0]  exit_code,
   output logic [XLEN-1:0]  fault_pc,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
);

   localparam logic [2:0] S_HOLD    = 3'd0;
   localparam logic [2:0] S_RUN     = 3'd1;
   localparam logic [2:0] S_HALTED  = 3'd2;
   localparam logic [2:0] S_FAULT   = 3'd3;
   localparam logic [2:0] S_TIMEOUT = 3'd4;

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int LW = $clog2(LOOP_LIMIT + 1);

   localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0]    LOOP_MAX  = LW'(LOOP_LIMIT);
   localparam logic [31:0]      INST_ECALL = 32'h0000_0073;
   localparam logic [31:0]      INST_JAL0  = 32'h0000_006F;

   logic [HW-1:0]   hold_cnt;
   logic [LW-1:0]   loop_cnt;
   logic [LW-1:0]   loop_next;
   logic [XLEN-1:0] loop_pc;
   logic [XLEN-1:0] last_pc;
   logic [XLEN-1:0] end_pc;
   logic            fault_ev;
   logic            halt_ev;
   logic            tmo_ev;

   // loop_next is the run length of identical self-loop retirements including this cycle
   always_comb begin
      loop_next = '0;
      if (retire_valid && retire_inst == INST_JAL0) begin
         if (loop_cnt != '0 && retire_pc == loop_pc)
            loop_next = (loop_cnt == LOOP_MAX) ? loop_cnt : loop_cnt + LW'(1);
         else
            loop_next = LW'(1);
      end
      fault_ev = retire_valid && (retire_pc[1:0] != 2'b00);
      halt_ev  = halt_req ||
                 (retire_valid && (retire_inst == INST_ECALL || loop_next == LOOP_MAX));
      tmo_ev   = (cycle_count == TMO_LAST);
      end_pc   = retire_valid ? retire_pc : last_pc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_HOLD;
         core_reset   <= 1'b1;
         hold_cnt     <= '0;
         done         <= 1'b0;
         pass         <= 1'b0;
         exit_code    <= '0;
         fault_pc     <= '0;
         cycle_count  <= '0;
         retire_count <= '0;
         loop_cnt     <= '0;
         loop_pc      <= '0;
         last_pc      <= '0;
      end else begin
         case (state)
            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state      <= S_RUN;
                  core_reset <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            S_RUN: begin
               cycle_count <= cycle_count + CNT_W'(1);
               if (retire_valid) begin
                  retire_count <= retire_count + CNT_W'(1);
                  last_pc      <= retire_pc;
                  loop_cnt     <= loop_next;
                  loop_pc      <= retire_pc;
               end
               if (fault_ev) begin
                  state     <= S_FAULT;
                  done      <= 1'b1;
                  exit_code <= a0_value;
                  fault_pc  <= retire_pc;
               end else if (halt_ev) begin
                  state     <= S_HALTED;
                  done      <= 1'b1;
                  pass      <= (a0_value == '0);
                  exit_code <= a0_value;
                  fault_pc  <= end_pc;
               end else if (tmo_ev) begin
                  state    <= S_TIMEOUT;
                  done     <= 1'b1;
                  fault_pc <= end_pc;
               end
            end
            // terminal states hold everything until reset so the core can be inspected
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - directed and randomized trace checks for cpu_run_monitor
module tb_cpu_run_monitor;

   localparam int TMO  = 50;
   localparam int LOOP = 2;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] JAL0  = 32'h0000_006F;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_reset;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic [31:0] retire_inst = '0;
   logic [31:0] a0_value = '0;
   logic        halt_req = 1'b0;
   logic [2:0]  state;
   logic        done;
   logic        pass;
   logic [31:0] exit_code;
   logic [31:0] fault_pc;
   logic [31:0] cycle_count;
   logic [31:0] retire_count;

   int checks = 0;
   int failures = 0;

   logic        tv   [64];
   logic [31:0] tpc  [64];
   logic [31:0] tinst[64];
   logic [31:0] ta0  [64];
   logic        thr  [64];

   logic [2:0]  e_state;
   logic        e_pass;
   logic [31:0] e_exit, e_fpc, e_cyc, e_rc;

   cpu_run_monitor #(
      .XLEN(32), .RESET_CYCLES(4), .TIMEOUT_CYCLES(TMO), .CNT_W(32), .LOOP_LIMIT(LOOP)
   ) dut (
      .clk(clk), .reset(reset), .core_reset(core_reset),
      .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
      .a0_value(a0_value), .halt_req(halt_req), .state(state), .done(done), .pass(pass),
      .exit_code(exit_code), .fault_pc(fault_pc),
      .cycle_count(cycle_count), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      retire_valid = 1'b0;
      retire_pc    = '0;
      retire_inst  = NOP;
      a0_value     = '0;
      halt_req     = 1'b0;
   endtask

   task automatic clear_trace();
      for (int i = 0; i < 64; i++) begin
         tv[i] = 1'b0; tpc[i] = '0; tinst[i] = NOP; ta0[i] = '0; thr[i] = 1'b0;
      end
   endtask

   // Reset, then walk through HOLD with a bogus misaligned ecall retiring that must be ignored
   task automatic do_reset(input bit verbose);
      idle_inputs();
      reset = 1'b1;
      repeat (3) tick();
      if (verbose) begin
         chk("rst_state", state, 0);
         chk("rst_core_reset", core_reset, 1);
         chk("rst_done", done, 0);
         chk("rst_pass", pass, 0);
         chk("rst_exit", exit_code, 0);
         chk("rst_fpc", fault_pc, 0);
         chk("rst_cyc", cycle_count, 0);
         chk("rst_rc", retire_count, 0);
      end
      reset        = 1'b0;
      retire_valid = 1'b1;
      retire_inst  = ECALL;
      retire_pc    = 32'h0000_0102;
      halt_req     = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         if (verbose && e < 4) begin
            chk($sformatf("hold_core_reset_e%0d", e), core_reset, 1);
            chk($sformatf("hold_state_e%0d", e), state, 0);
         end
      end
      chk("run_entry_state", state, 1);
      chk("run_entry_core_reset", core_reset, 0);
      if (verbose) begin
         chk("run_entry_cyc", cycle_count, 0);
         chk("run_entry_rc", retire_count, 0);
      end
      idle_inputs();
   endtask

   // Trace-level reference: scan RUN cycles for the first terminating event
   task automatic model();
      int          rc, run;
      logic [31:0] run_pc, lastpc;
      logic        mis, hlt, fin;
      rc = 0; run = 0; run_pc = '0; lastpc = '0; fin = 1'b0;
      e_state = 3'd4; e_exit = '0; e_fpc = '0; e_pass = 1'b0; e_cyc = TMO; e_rc = '0;
      for (int i = 0; i < TMO; i++) begin
         if (!fin) begin
            mis = 1'b0; hlt = thr[i];
            if (tv[i]) begin
               rc++;
               mis = (tpc[i][1:0] != 2'b00);
               if (tinst[i] == JAL0 && run > 0 && tpc[i] == run_pc) run++;
               else if (tinst[i] == JAL0) begin run = 1; run_pc = tpc[i]; end
               else run = 0;
               if (tinst[i] == ECALL || run >= LOOP) hlt = 1'b1;
            end
            if (mis) begin
               e_state = 3'd3; e_exit = ta0[i]; e_fpc = tpc[i]; fin = 1'b1;
            end else if (hlt) begin
               e_state = 3'd2; e_exit = ta0[i]; e_pass = (ta0[i] == 0);
               e_fpc = tv[i] ? tpc[i] : lastpc; fin = 1'b1;
            end else if (i == TMO - 1) begin
               e_state = 3'd4; e_fpc = tv[i] ? tpc[i] : lastpc; fin = 1'b1;
            end
            if (tv[i]) lastpc = tpc[i];
            if (fin) begin e_cyc = i + 1; e_rc = rc; end
         end
      end
   endtask

   task automatic run_trace(input string tag, input int n);
      int k;
      model();
      do_reset(1'b0);
      for (int i = 0; i < n; i++) begin
         retire_valid = tv[i]; retire_pc = tpc[i]; retire_inst = tinst[i];
         a0_value = ta0[i]; halt_req = thr[i];
         tick();
      end
      idle_inputs();
      k = 0;
      while (!done && k < 80) begin tick(); k++; end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_state"}, state, e_state);
      chk({tag, "_pass"}, pass, e_pass);
      chk({tag, "_exit"}, exit_code, e_exit);
      chk({tag, "_fpc"}, fault_pc, e_fpc);
      chk({tag, "_cyc"}, cycle_count, e_cyc);
      chk({tag, "_rc"}, retire_count, e_rc);
   endtask

   initial begin
      logic [31:0] pcs[3];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200;

      do_reset(1'b1);

      // ecall halt after 10 retirements with bubbles, then verify freeze
      clear_trace();
      for (int i = 0; i < 10; i++) begin
         tv[2*i] = 1'b1; tpc[2*i] = 32'h1000 + 4*i; ta0[2*i] = 32'h55;
      end
      tinst[18] = ECALL; ta0[18] = 32'h0;
      run_trace("ecall", 19);
      chk("ecall_pass_const", pass, 1);
      chk("ecall_rc_const", retire_count, 10);
      retire_valid = 1'b1; retire_inst = ECALL; retire_pc = 32'h2000; a0_value = 32'h9;
      halt_req = 1'b1;
      repeat (5) tick();
      idle_inputs();
      chk("freeze_state", state, 2);
      chk("freeze_rc", retire_count, 10);
      chk("freeze_cyc", cycle_count, e_cyc);
      chk("freeze_exit", exit_code, 0);
      chk("freeze_core_reset", core_reset, 0);

      // self-loop jal at same pc with a bubble between
      clear_trace();
      tv[0] = 1; tpc[0] = 32'h100; tinst[0] = JAL0; ta0[0] = 32'h7;
      tv[2] = 1; tpc[2] = 32'h100; tinst[2] = JAL0; ta0[2] = 32'h7;
      run_trace("selfloop", 3);
      chk("selfloop_exit_const", exit_code, 7);

      // alternating pc never forms a loop, ends in timeout
      clear_trace();
      for (int i = 0; i < 40; i++) begin
         tv[i] = 1; tinst[i] = JAL0; tpc[i] = (i % 2) ? 32'h104 : 32'h100;
      end
      run_trace("altloop", 40);
      chk("altloop_state_const", state, 4);

      // misaligned pc beats ecall in the same retirement
      clear_trace();
      tv[3] = 1; tpc[3] = 32'h102; tinst[3] = ECALL; ta0[3] = 32'h0;
      run_trace("fault", 4);
      chk("fault_fpc_const", fault_pc, 32'h102);

      // pure timeout, then halt_req on the last allowed cycle
      clear_trace();
      run_trace("timeout", 0);
      chk("timeout_cyc_const", cycle_count, TMO);
      clear_trace();
      thr[TMO-1] = 1; ta0[TMO-1] = 32'h3;
      tv[5] = 1; tpc[5] = 32'h300;
      run_trace("halt_last", TMO);

      // asynchronous reset between edges mid-run
      do_reset(1'b0);
      retire_valid = 1'b1; retire_pc = 32'h400; retire_inst = NOP;
      repeat (6) tick();
      #3 reset = 1'b1;
      #1;
      chk("async_state", state, 0);
      chk("async_core_reset", core_reset, 1);
      chk("async_cyc", cycle_count, 0);
      chk("async_rc", retire_count, 0);

      // randomized traces
      for (int r = 0; r < 40; r++) begin
         int n;
         logic [31:0] prev;
         clear_trace();
         n = $urandom_range(5, 45);
         prev = 32'h100;
         for (int i = 0; i < n; i++) begin
            int sel;
            tv[i] = ($urandom_range(0, 3) != 0);
            tpc[i] = ($urandom_range(0, 1) == 0) ? prev : pcs[$urandom_range(0, 2)];
            if ($urandom_range(0, 59) == 0) tpc[i] = tpc[i] + 32'd2;
            prev = tpc[i];
            sel = $urandom_range(0, 49);
            tinst[i] = (sel == 0) ? ECALL : (sel < 12) ? JAL0 : NOP;
            ta0[i] = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            thr[i] = ($urandom_range(0, 79) == 0);
         end
         run_trace($sformatf("rand%0d", r), n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
